// File: rtl/tmr_pipe_alu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tmr_pipe_alu
//  Function : Two-stage triple-modular-redundant add/subtract unit with input
//             checking, majority voting, per-replica error counters, replica
//             retirement and a sticky OK/DEGRADED/FAILED health state.
//  Revision : 1.0  initial release
// ============================================================================
module tmr_pipe_alu #(
    parameter int WIDTH     = 8,
    parameter int ERR_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             par,
    input  logic [2:0]       ctl,
    input  logic [2:0]       inject,
    input  logic             clear,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             err_in,
    output logic             err_cor,
    output logic             err_unc,
    output logic [1:0]       health,
    output logic [2:0]       retired
);

    typedef enum logic [1:0] {
        H_OK   = 2'b00,
        H_DEG  = 2'b01,
        H_FAIL = 2'b10
    } health_t;

    localparam logic [3:0] LIMIT_C = 4'(ERR_LIMIT);

    logic [2:0][WIDTH:0] w_res;
    logic                w_chk_ok;

    logic [2:0][WIDTH:0] s1_res_q;
    logic                s1_valid_q;
    logic                s1_ok_q;

    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    sum_q, sum_d;
    logic                cout_q, cout_d;
    logic                err_in_q, err_in_d;
    logic                err_cor_q, err_cor_d;
    logic                err_unc_q, err_unc_d;
    health_t             health_q, health_d;
    logic [2:0]          retired_q, retired_d;
    logic [2:0][3:0]     cnt_q, cnt_d;

    // Odd parity over {a,b,par} and a strictly one-hot opcode.
    assign w_chk_ok = (^{a, b, par}) &&
                      ((ctl == 3'b001) || (ctl == 3'b010) || (ctl == 3'b100));

    // Three independent ripple-carry replicas, each with its own operand mux.
    for (genvar gi = 0; gi < 3; gi++) begin : g_rep
        logic [WIDTH:0] w_r;
        // Bit-serial carry chain so each replica is a genuine ripple adder.
        always_comb begin
            logic [WIDTH-1:0] x;
            logic [WIDTH-1:0] y;
            logic             c;
            w_r = '0;
            x   = a;
            y   = b;
            c   = 1'b0;
            if (ctl == 3'b010) begin
                y = ~b;
                c = 1'b1;
            end else if (ctl == 3'b100) begin
                x = ~a;
                c = 1'b1;
            end
            for (int k = 0; k < WIDTH; k++) begin
                w_r[k] = x[k] ^ y[k] ^ c;
                c      = (x[k] & y[k]) | (c & (x[k] ^ y[k]));
            end
            w_r[WIDTH] = c;
        end
        assign w_res[gi] = w_r;
    end

    // Stage 1: capture replica results (with fault injection on sum bit 0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_res_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_ok_q    <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                s1_res_q[i] <= w_res[i] ^ {{WIDTH{1'b0}}, inject[i]};
            end
            s1_valid_q <= in_valid;
            s1_ok_q    <= w_chk_ok;
        end
    end

    // Stage 2 next state: vote, flag errors, update counters/retire/health.
    always_comb begin
        logic [WIDTH:0] val;
        logic [WIDTH:0] pa;
        logic [WIDTH:0] pb;
        logic [2:0]     dis;
        logic [2:0]     agree;
        out_valid_d = s1_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        err_in_d    = 1'b0;
        err_cor_d   = 1'b0;
        err_unc_d   = 1'b0;
        health_d    = health_q;
        retired_d   = retired_q;
        cnt_d       = cnt_q;
        val         = '0;
        pa          = '0;
        pb          = '0;
        dis         = 3'b000;
        agree       = 3'b000;
        if (s1_valid_q) begin
            if (!s1_ok_q) begin
                err_in_d = 1'b1;
            end else begin
                case (health_q)
                    H_OK: begin
                        if (s1_res_q[0] == s1_res_q[1] && s1_res_q[0] == s1_res_q[2]) begin
                            val   = s1_res_q[0];
                            agree = 3'b111;
                        end else if (s1_res_q[0] == s1_res_q[1]) begin
                            val   = s1_res_q[0];
                            dis   = 3'b100;
                            agree = 3'b011;
                        end else if (s1_res_q[0] == s1_res_q[2]) begin
                            val   = s1_res_q[0];
                            dis   = 3'b010;
                            agree = 3'b101;
                        end else if (s1_res_q[1] == s1_res_q[2]) begin
                            val   = s1_res_q[1];
                            dis   = 3'b001;
                            agree = 3'b110;
                        end else begin
                            err_unc_d = 1'b1;
                            health_d  = H_FAIL;
                        end
                        err_cor_d = |dis;
                        for (int k = 0; k < 3; k++) begin
                            if (!retired_q[k]) begin
                                if (dis[k]) begin
                                    if (cnt_q[k] < LIMIT_C) cnt_d[k] = cnt_q[k] + 4'd1;
                                    if (cnt_d[k] == LIMIT_C) begin
                                        retired_d[k] = 1'b1;
                                        health_d     = H_DEG;
                                    end
                                end else if (agree[k]) begin
                                    cnt_d[k] = 4'd0;
                                end
                            end
                        end
                    end
                    H_DEG: begin
                        // Only the two surviving replicas are compared.
                        if (retired_q[0]) begin
                            pa = s1_res_q[1];
                            pb = s1_res_q[2];
                        end else if (retired_q[1]) begin
                            pa = s1_res_q[0];
                            pb = s1_res_q[2];
                        end else begin
                            pa = s1_res_q[0];
                            pb = s1_res_q[1];
                        end
                        if (pa == pb) begin
                            val = pa;
                        end else begin
                            err_unc_d = 1'b1;
                            health_d  = H_FAIL;
                        end
                    end
                    default: begin
                        err_unc_d = 1'b1;
                    end
                endcase
            end
            {cout_d, sum_d} = val;
        end
        // Clear affects only the state; the result above used the old state.
        if (clear) begin
            health_d  = H_OK;
            retired_d = 3'b000;
            cnt_d     = '0;
        end
    end

    // Stage 2 registers: outputs and health state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            err_in_q    <= 1'b0;
            err_cor_q   <= 1'b0;
            err_unc_q   <= 1'b0;
            health_q    <= H_OK;
            retired_q   <= 3'b000;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            err_in_q    <= err_in_d;
            err_cor_q   <= err_cor_d;
            err_unc_q   <= err_unc_d;
            health_q    <= health_d;
            retired_q   <= retired_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign err_in    = err_in_q;
    assign err_cor   = err_cor_q;
    assign err_unc   = err_unc_q;
    assign health    = health_q;
    assign retired   = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_tmr_pipe_alu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_tmr_pipe_alu
//  Function : Directed, table-driven self-checking bench for tmr_pipe_alu
//             (WIDTH=8, ERR_LIMIT=3).
//  Revision : 1.0  initial release
// ============================================================================
module tb_tmr_pipe_alu;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       par = 1'b0;
    logic [2:0] ctl = 3'b001;
    logic [2:0] inject = 3'b000;
    logic       clear = 1'b0;
    logic       out_valid;
    logic [7:0] sum;
    logic       cout;
    logic       err_in;
    logic       err_cor;
    logic       err_unc;
    logic [1:0] health;
    logic [2:0] retired;

    int n_cmp = 0;
    int n_bad = 0;

    tmr_pipe_alu #(.WIDTH(8), .ERR_LIMIT(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .par(par),
        .ctl(ctl), .inject(inject), .clear(clear), .out_valid(out_valid),
        .sum(sum), .cout(cout), .err_in(err_in), .err_cor(err_cor),
        .err_unc(err_unc), .health(health), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       badp;
        logic [2:0] ctl;
        logic [2:0] inj;
        logic       clr;
        logic [7:0] esum;
        logic       ecout;
        logic       ein;
        logic       ecor;
        logic       eunc;
        logic [1:0] eh;
        logic [2:0] eret;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [7:0] a_, input logic [7:0] b_,
                                input logic badp_, input logic [2:0] ctl_,
                                input logic [2:0] inj_, input logic clr_,
                                input logic [7:0] esum_, input logic ecout_,
                                input logic ein_, input logic ecor_, input logic eunc_,
                                input logic [1:0] eh_, input logic [2:0] eret_);
        vec_t v;
        v.a = a_; v.b = b_; v.badp = badp_; v.ctl = ctl_; v.inj = inj_; v.clr = clr_;
        v.esum = esum_; v.ecout = ecout_; v.ein = ein_; v.ecor = ecor_; v.eunc = eunc_;
        v.eh = eh_; v.eret = eret_;
        tbl.push_back(v);
    endfunction

    // {out_valid, sum, cout, err_in, err_cor, err_unc, health, retired}
    function automatic logic [17:0] pack_out();
        return {out_valid, sum, cout, err_in, err_cor, err_unc, health, retired};
    endfunction

    task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_op(input logic [7:0] a_, input logic [7:0] b_, input logic badp_,
                            input logic [2:0] ctl_, input logic [2:0] inj_);
        a        = a_;
        b        = b_;
        ctl      = ctl_;
        inject   = inj_;
        par      = badp_ ? (^a_ ^ ^b_) : ~(^a_ ^ ^b_);
        in_valid = 1'b1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clk);
        drive_op(v.a, v.b, v.badp, v.ctl, v.inj);
        clear = v.clr;
        @(negedge clk);
        in_valid = 1'b0;
        inject   = 3'b000;
        clear    = 1'b0;
        @(negedge clk);
        chk($sformatf("vec%0d", idx), pack_out(),
            {1'b1, v.esum, v.ecout, v.ein, v.ecor, v.eunc, v.eh, v.eret});
        @(negedge clk);
        chk($sformatf("vec%0d_idle", idx), pack_out(),
            {1'b0, v.esum, v.ecout, 3'b000, v.eh, v.eret});
    endtask

    initial begin
        //   a      b     bad  ctl     inj     clr   sum    co    ein   cor   unc   hlth   ret
        add(8'h7F, 8'h01, 1'b0, 3'b001, 3'b000, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000);
        add(8'h05, 8'h07, 1'b0, 3'b010, 3'b000, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000);
        add(8'h05, 8'h07, 1'b0, 3'b100, 3'b000, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000);
        add(8'hFF, 8'h01, 1'b0, 3'b001, 3'b000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000);
        add(8'h12, 8'h34, 1'b1, 3'b001, 3'b000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000);
        add(8'h12, 8'h34, 1'b0, 3'b011, 3'b000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000);
        add(8'h12, 8'h34, 1'b0, 3'b000, 3'b000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000);
        add(8'h10, 8'h20, 1'b0, 3'b001, 3'b001, 1'b0, 8'h30, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000);
        add(8'h01, 8'h01, 1'b0, 3'b001, 3'b000, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000);
        add(8'h03, 8'h04, 1'b0, 3'b001, 3'b001, 1'b0, 8'h07, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000);
        add(8'h03, 8'h04, 1'b0, 3'b001, 3'b001, 1'b0, 8'h07, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000);
        add(8'h03, 8'h04, 1'b1, 3'b001, 3'b001, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000);
        add(8'h00, 8'h00, 1'b0, 3'b001, 3'b001, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 3'b001);
        add(8'h02, 8'h03, 1'b0, 3'b001, 3'b001, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b001);
        add(8'h02, 8'h03, 1'b0, 3'b001, 3'b010, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b001);
        add(8'h01, 8'h01, 1'b0, 3'b001, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b001);
        add(8'h01, 8'h02, 1'b0, 3'b001, 3'b000, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000);
        add(8'h00, 8'h00, 1'b0, 3'b001, 3'b111, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000);
        add(8'h00, 8'h00, 1'b0, 3'b001, 3'b011, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000);
        add(8'h80, 8'h80, 1'b0, 3'b001, 3'b000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000);
        add(8'h01, 8'h01, 1'b0, 3'b001, 3'b001, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000);
        add(8'h01, 8'h01, 1'b0, 3'b001, 3'b001, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000);
        add(8'h01, 8'h01, 1'b0, 3'b001, 3'b001, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 3'b001);

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_state", pack_out(), 18'h0);
        rst = 1'b0;

        foreach (tbl[i]) run_vec(i, tbl[i]);

        // Clear on the voting edge: result judged as DEGRADED, state cleared.
        @(negedge clk);
        drive_op(8'h02, 8'h03, 1'b0, 3'b001, 3'b010);
        @(negedge clk);
        in_valid = 1'b0;
        inject   = 3'b000;
        clear    = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_same_edge", pack_out(), {1'b1, 8'h00, 1'b0, 3'b001, 2'b00, 3'b000});

        // Back-to-back stream, reset asserted mid-stream.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i >= 2)
                chk($sformatf("stream%0d", i - 2), pack_out(),
                    {1'b1, 8'(3 * (i - 2) + 1), 1'b0, 3'b000, 2'b00, 3'b000});
            drive_op(8'(3 * i), 8'h01, 1'b0, 3'b001, 3'b000);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_async", pack_out(), 18'h0);
        for (int i = 8; i < 12; i++) begin
            @(negedge clk);
            drive_op(8'(3 * i), 8'h01, 1'b0, 3'b001, 3'b000);
        end
        @(negedge clk);
        chk("rst_held", pack_out(), 18'h0);
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            if (j > 0) @(negedge clk);
            if (j < 2)
                chk($sformatf("post_rst_nostale%0d", j), {17'h0, out_valid}, 18'h0);
            else
                chk($sformatf("post_rst%0d", j - 2), pack_out(),
                    {1'b1, 8'(3 * (j + 10) + 1), 1'b0, 3'b000, 2'b00, 3'b000});
            if (j < 4) drive_op(8'(3 * (j + 12)), 8'h01, 1'b0, 3'b001, 3'b000);
            else in_valid = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tmr_pipe_alu.md
TMR_PIPE_ALU -- requirements
Module: tmr_pipe_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width, legal range 2..32.
REQ-002 SHALL have parameter ERR_LIMIT, default 3: consecutive minority votes before a replica is retired, range 1..15.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1: operand set present this cycle.
REQ-007 SHALL have port a, input, WIDTH: operand A.
REQ-008 SHALL have port b, input, WIDTH: operand B.
REQ-009 SHALL have port par, input, 1: parity bit; XOR of a, b and par is 1 (odd) when correct.
REQ-010 SHALL have port ctl, input, 3: one-hot op; 001 A+B, 010 A-B, 100 B-A.
REQ-011 SHALL have port inject, input, 3: test-only; bit i inverts sum bit 0 of replica i before its stage-1 register.
REQ-012 SHALL have port clear, input, 1: synchronous clear of the health state, counters and retire mask.
REQ-013 SHALL have port out_valid, output, 1: result valid.
REQ-014 SHALL have port sum, output, WIDTH: voted result.
REQ-015 SHALL have port cout, output, 1: voted carry-out.
REQ-016 SHALL have port err_in, output, 1: input parity or one-hot error for this result.
REQ-017 SHALL have port err_cor, output, 1: one replica disagreed and was outvoted.
REQ-018 SHALL have port err_unc, output, 1: no majority or agreement; result untrustworthy.
REQ-019 SHALL have port health, output, 2: 00 OK, 01 DEGRADED, 10 FAILED.
REQ-020 SHALL have port retired, output, 3: bit i set when replica i is retired.

Function
REQ-021 SHALL instantiate three independent WIDTH-bit ripple-carry replicas fed by identical operands: add uses cin=0; A-B uses a + ~b with cin=1; B-A uses ~a + b with cin=1.
REQ-022 Stage 1 SHALL register each replica's {cout,sum}, in_valid, and the check result (parity odd AND ctl exactly one-hot).
REQ-023 Stage 2 SHALL vote and register the outputs; in_valid at edge T gives out_valid at edge T+2, one result per cycle, no stalls.
REQ-024 A check failure SHALL produce out_valid=1, err_in=1, sum=0, cout=0, err_cor=0, err_unc=0, and SHALL leave the counters unchanged.
REQ-025 In OK, the voter SHALL output the majority {cout,sum}; a single dissenter sets err_cor; three distinct values set err_unc, output 0, and health goes to FAILED.
REQ-026 Per replica, a saturating counter SHALL increment on each valid, check-passing result where that replica is the dissenter, and clear to 0 when it agrees.
REQ-027 When a counter reaches ERR_LIMIT, that replica's retired bit SHALL set on the same edge, and health goes OK->DEGRADED.
REQ-028 In DEGRADED, the two remaining replicas SHALL be compared; on agreement, output their value; on mismatch, err_unc=1, output 0, and health goes to FAILED.
REQ-029 In FAILED, every valid result SHALL be sum=0, cout=0, err_unc=1; FAILED is left only by clear or rst.
REQ-030 clear SHALL return health to OK and zero the counters and retired; the pipeline is not flushed, and a result voting on the same edge is judged under the pre-clear state.
REQ-031 out_valid SHALL be 0 and all error flags 0 on cycles with no valid result; sum/cout hold their last value.
REQ-032 Counters SHALL not wrap; a retired replica's counter is frozen.

Reset
REQ-033 rst SHALL immediately clear both pipeline valid bits, sum, cout, all error flags, counters and retired, and set health to OK; in-flight operations are discarded.
REQ-034 The first valid input after rst deassertion SHALL appear 2 cycles later.

Verification
REQ-035 WIDTH=8: a=0x7F, b=0x01, ctl=001, par valid -> T+2: sum=0x80, cout=0, no errors; ctl=010, a=0x05, b=0x07 -> sum=0xFE, cout=0.
REQ-036 Bad parity, or ctl=011 -> out_valid=1, err_in=1, sum=0, health unchanged.
REQ-037 inject=001 on one op -> correct sum, err_cor=1; with ERR_LIMIT=3, three consecutive injected ops -> retired=001, health=01 on the third result's edge.
REQ-038 While DEGRADED, inject=010 -> err_unc=1, sum=0, health=10; later clean ops stay err_unc; a clear pulse -> health=00 and retired=000.
REQ-039 Back-to-back valid stream of 16 ops with rst asserted mid-stream -> outputs zero immediately, no stale out_valid after release.
REQ-040 inject=111 on a single op with a=0x00, b=0x00, ctl=001 -> all three replicas agree on 0x01 (undetectable common-mode fault, documented limit); inject=011 -> two replicas agree on the wrong value and the healthy replica 2 is outvoted (err_cor=1, wrong sum), confirming the single-fault coverage boundary.
